// File: rtl/rr_mux_n.sv
// rr_mux_n: N:1 round-robin valid/ready mux with registered output; RR_MUX_LOCK_EN adds packet lock via in_last/out_last
module rr_mux_n #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int SW    = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
`ifdef RR_MUX_LOCK_EN
    input  logic [N-1:0]       in_last,
    output logic               out_last,
`endif
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SW-1:0]      out_sel
);
    logic [SW-1:0] ptr;
    logic [SW-1:0] gidx;
    logic [SW-1:0] nptr;
    logic [N-1:0]  grant;
    logic          load_en;
`ifdef RR_MUX_LOCK_EN
    logic          lock;
    logic [SW-1:0] lock_idx;
`endif

    assign load_en  = !out_valid || out_ready;
    assign in_ready = grant & {N{load_en && !rst}};
    assign nptr     = (gidx == SW'(N - 1)) ? '0 : gidx + 1'b1;

    // first valid channel searching from ptr upward with wrap; a held lock overrides the search
    always_comb begin : arb
        logic [SW:0]   s;
        logic [SW-1:0] idx;
        grant = '0;
        gidx  = '0;
        s     = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            s   = {1'b0, ptr} + (SW+1)'(k);
            idx = (s >= (SW+1)'(N)) ? SW'(s - (SW+1)'(N)) : SW'(s);
            if (grant == '0 && in_valid[idx]) begin
                grant[idx] = 1'b1;
                gidx       = idx;
            end
        end
`ifdef RR_MUX_LOCK_EN
        if (lock) begin
            grant           = '0;
            grant[lock_idx] = in_valid[lock_idx];
            gidx            = lock_idx;
        end
`endif
    end

    // output register and pointer: load on accept, drain to empty when nothing is offered
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
`ifdef RR_MUX_LOCK_EN
            lock      <= 1'b0;
            lock_idx  <= '0;
            out_last  <= 1'b0;
`endif
        end else if (load_en) begin
            out_valid <= |grant;
            if (|grant) begin
                out_data <= in_data[gidx*WIDTH +: WIDTH];
                out_sel  <= gidx;
`ifdef RR_MUX_LOCK_EN
                out_last <= in_last[gidx];
                lock     <= !in_last[gidx];
                lock_idx <= gidx;
                if (in_last[gidx]) ptr <= nptr;
`else
                ptr      <= nptr;
`endif
            end
        end
    end
endmodule
